// File: rtl/paddle_ai_pkg.sv
// paddle_ai_pkg: shared constants for the computer-player paddle controller.
//   - Key command encodings (active-low up/down pair, same as a human key pair)
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - Screen geometry reused from the game configuration
//   - LFSR seed and the aim-jitter helper
package paddle_ai_pkg;

    // Key commands driven into the paddle block.
    localparam logic [1:0] KEY_UP   = 2'b01;
    localparam logic [1:0] KEY_DN   = 2'b10;
    localparam logic [1:0] KEY_IDLE = 2'b11;

    // Controller states.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REACT   = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_MOVE_UP = 3'd3;
    localparam logic [2:0] ST_MOVE_DN = 3'd4;

    // Screen geometry shared with the rest of the game.
    localparam logic [9:0] V_DISP = 10'd480;   // visible lines
    localparam logic [9:0] SLDE_W = 10'd10;    // border (slide) width
    localparam logic [9:0] BODY_L = 10'd40;    // paddle body length

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Aim jitter from the low LFSR nibble: -8..+7 px, 5-bit two's complement.
    function automatic logic [4:0] aim_from_lfsr(input logic [7:0] v);
        return {1'b0, v[3:0]} - 5'd8;
    endfunction

    // Raw key command for a state, before the screen-limit guard.
    function automatic logic [1:0] key_for_state(input logic [2:0] st);
        case (st)
            ST_MOVE_UP: return KEY_UP;
            ST_MOVE_DN: return KEY_DN;
            default:    return KEY_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   clk : clock
//   rst : synchronous active-high reset, loads LFSR_SEED
//   adv : advance one step when high
//   q   : current LFSR value
module lfsr8
    import paddle_ai_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] q
);

    logic fb;

    // Taps at bits 8,6,5,4 of the polynomial map to q[7],q[5],q[4],q[3].
    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)
            q <= LFSR_SEED;
        else if (adv)
            q <= {q[6:0], fb};
    end

endmodule

// File: rtl/paddle_ai.sv
// paddle_ai: computer-player paddle controller. Watches the ball and the
// paddle position and synthesises the active-low up/down key pair.
//   vga_clk       : system clock
//   sys_rst       : synchronous active-high reset
//   enable        : AI drives the paddle when high
//   guiwei        : round restart pulse, synchronous clear
//   ball_y        : ball top-left y
//   ball_approach : ball moving toward this paddle
//   paddle_y      : paddle top-left y (fed back from body_y)
//   key_out       : 2'b10 down, 2'b01 up, 2'b11 idle (registered)
module paddle_ai
    import paddle_ai_pkg::*;
#(
    parameter logic [21:0] DECIDE_DIV  = 22'd190000,
    parameter logic [3:0]  REACT_TICKS = 4'd3,
    parameter logic [9:0]  DEAD_ZONE   = 10'd6,
    parameter logic [9:0]  STOP_BAND   = 10'd2,
    parameter logic [9:0]  BALL_W      = 10'd10,
    parameter logic        AIM_EN      = 1'b1
)(
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       enable,
    input  logic       guiwei,
    input  logic [9:0] ball_y,
    input  logic       ball_approach,
    input  logic [9:0] paddle_y,
    output logic [1:0] key_out
);

    localparam logic [11:0] HALF_BALL  = {2'b00, BALL_W >> 1};
    localparam logic [11:0] HALF_BODY  = {2'b00, BODY_L >> 1};
    localparam logic [11:0] MID_SCREEN = {2'b00, V_DISP >> 1};
    localparam logic [11:0] Y_MAX      = {2'b00, V_DISP - 10'd1};
    localparam logic [9:0]  DN_LIMIT   = V_DISP - SLDE_W - BODY_L;

    localparam logic signed [10:0] DEAD_HI = $signed({1'b0, DEAD_ZONE});
    localparam logic signed [10:0] DEAD_LO = -DEAD_HI;
    localparam logic signed [10:0] STOP_HI = $signed({1'b0, STOP_BAND});
    localparam logic signed [10:0] STOP_LO = -STOP_HI;

    logic [21:0]        div_cnt;
    logic               tick;
    logic [2:0]         state, state_nxt;
    logic [3:0]         react_cnt;
    logic               approach_q, approach_rise, react_entry;
    logic [7:0]         lfsr_q;
    logic [4:0]         aim_off, aim_next;
    logic [11:0]        target_raw, target, centre;
    logic signed [11:0] err_wide;
    logic signed [10:0] err;
    logic [1:0]         key_nxt;

    assign tick          = (div_cnt == DECIDE_DIV - 22'd1);
    assign approach_rise = ball_approach & ~approach_q;
    // A rise only starts REACT when nothing of higher priority claims the cycle.
    assign react_entry   = approach_rise & enable & ~guiwei;
    assign aim_next      = AIM_EN ? aim_from_lfsr(lfsr_q) : 5'd0;

    lfsr8 u_lfsr (
        .clk (vga_clk),
        .rst (sys_rst),
        .adv (tick),
        .q   (lfsr_q)
    );

    // Target and error. Arithmetic is 12-bit so negative jitter and large
    // paddle positions cannot wrap before clamping/saturation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        target_raw = MID_SCREEN;
        if (ball_approach)
            target_raw = {2'b00, ball_y} + HALF_BALL + {{7{aim_off[4]}}, aim_off};

        if (target_raw[11])
            target = '0;
        else if (target_raw > Y_MAX)
            target = Y_MAX;
        else
            target = target_raw;

        centre   = {2'b00, paddle_y} + HALF_BODY;
        err_wide = $signed(target) - $signed(centre);

        if (err_wide < -12'sd1024)
            err = 11'sh400;
        else
            err = err_wide[10:0];
    end

    // Next state: guiwei, then enable, then ball_approach rise, then tick rules.
    always_comb begin
        state_nxt = state;
        if (guiwei)
            state_nxt = enable ? ST_HOLD : ST_IDLE;
        else if (!enable)
            state_nxt = ST_IDLE;
        else if (approach_rise)
            state_nxt = ST_REACT;
        else if (tick) begin
            case (state)
                ST_IDLE:  state_nxt = ST_HOLD;
                ST_REACT: if (react_cnt == REACT_TICKS - 4'd1) state_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (err > DEAD_HI)      state_nxt = ST_MOVE_DN;
                    else if (err < DEAD_LO) state_nxt = ST_MOVE_UP;
                end
                ST_MOVE_DN: begin
                    if (err >= STOP_LO && err <= STOP_HI) state_nxt = ST_HOLD;
                    else if (err < STOP_LO)               state_nxt = ST_MOVE_UP;
                end
                ST_MOVE_UP: begin
                    if (err >= STOP_LO && err <= STOP_HI) state_nxt = ST_HOLD;
                    else if (err > STOP_HI)               state_nxt = ST_MOVE_DN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Limit guard masks the command at the screen edges; it never alters state.
    always_comb begin
        key_nxt = key_for_state(state_nxt);
        if (state_nxt == ST_MOVE_DN && paddle_y >= DN_LIMIT)
            key_nxt = KEY_IDLE;
        if (state_nxt == ST_MOVE_UP && paddle_y <= SLDE_W)
            key_nxt = KEY_IDLE;
    end

    always_ff @(posedge vga_clk) begin
        // NOTE: all controller state is reset explicitly; there is no memory
        // array here, so nothing relies on power-up contents.
        if (sys_rst) begin
            div_cnt    <= '0;
            state      <= ST_IDLE;
            react_cnt  <= '0;
            approach_q <= 1'b0;
            aim_off    <= '0;
            key_out    <= KEY_IDLE;
        end else begin
            approach_q <= ball_approach;
            state      <= state_nxt;
            key_out    <= key_nxt;

            if (guiwei || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 22'd1;

            if (guiwei || react_entry)
                react_cnt <= '0;
            else if (state == ST_REACT && tick)
                react_cnt <= react_cnt + 4'd1;

            if (react_entry)
                aim_off <= aim_next;
        end
    end

endmodule

// File: tb/tb_paddle_ai.sv
// tb_paddle_ai: directed scoreboard bench for paddle_ai.
// Stimulus pushes the expected key_out value and the cycle it must appear on;
// a monitor pops and compares whenever key_out changes.
module tb_paddle_ai;
    import paddle_ai_pkg::*;

    localparam int DIV = 4;

    logic       vga_clk = 1'b0;
    logic       sys_rst, enable, guiwei, ball_approach;
    logic [9:0] ball_y, paddle_y;
    logic [1:0] key_out;

    typedef struct {
        logic [1:0] key;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         tb_div   = 0;
    bit         mon_en   = 1'b0;
    logic [1:0] prev_key = KEY_IDLE;
    exp_t       e;

    always #5 vga_clk = ~vga_clk;

    paddle_ai #(
        .DECIDE_DIV  (22'd4),
        .REACT_TICKS (4'd3),
        .DEAD_ZONE   (10'd6),
        .STOP_BAND   (10'd2),
        .BALL_W      (10'd10),
        .AIM_EN      (1'b0)
    ) dut (
        .vga_clk       (vga_clk),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .guiwei        (guiwei),
        .ball_y        (ball_y),
        .ball_approach (ball_approach),
        .paddle_y      (paddle_y),
        .key_out       (key_out)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Cycle counter and decision-tick reference: the strobe falls every DIV
    // cycles, restarted by sys_rst or guiwei.
    always @(posedge vga_clk) begin
        cyc <= cyc + 1;
        if (sys_rst || guiwei)
            tb_div <= 0;
        else if (tb_div == DIV - 1)
            tb_div <= 0;
        else
            tb_div <= tb_div + 1;
    end

    // Monitor: every key_out change must match the head of the scoreboard.
    always @(negedge vga_clk) begin
        if (mon_en) begin
            if (key_out !== prev_key) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key: got %b at cycle %0d, expected no change", key_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("key_value", {30'd0, key_out}, {30'd0, e.key});
                    check("key_cycle", cyc, e.cyc);
                end
            end
            prev_key <= key_out;
        end
    end

    // Called at a negedge: key_out must take value k after the next posedge.
    task automatic expect_key(input logic [1:0] k);
        exp_t x;
        x.key = k;
        x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    // Stay on this negedge if it is a tick cycle, else advance to one.
    task automatic wait_tick();
        int n = 0;
        while (tb_div != DIV - 1) begin
            @(negedge vga_clk);
            n++;
            if (n > 16) begin
                n_checks++;
                n_fail++;
                $display("FAIL tick_timeout: no tick within 16 cycles, expected one every %0d", DIV);
                break;
            end
        end
    endtask

    task automatic next_tick();
        @(negedge vga_clk);
        wait_tick();
    endtask

    initial begin
        sys_rst       = 1'b1;
        enable        = 1'b0;
        guiwei        = 1'b0;
        ball_approach = 1'b0;
        ball_y        = 10'd0;
        paddle_y      = 10'd100;

        // Reset state.
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("reset_key",   {30'd0, key_out},    {30'd0, KEY_IDLE});
        check("reset_state", {29'd0, dut.state},  {29'd0, ST_IDLE});
        check("reset_lfsr",  {24'd0, dut.lfsr_q}, 32'hA5);
        check("reset_div",   {10'd0, dut.div_cnt}, 32'd0);

        // Ball turns toward us: three ticks of reaction, then move down.
        sys_rst       = 1'b0;
        enable        = 1'b1;
        ball_y        = 10'd300;
        paddle_y      = 10'd100;
        ball_approach = 1'b1;
        mon_en        = 1'b1;
        @(negedge vga_clk);
        check("react_state", {29'd0, dut.state}, {29'd0, ST_REACT});
        wait_tick();
        next_tick();
        next_tick();
        @(negedge vga_clk);
        check("react_done_state", {29'd0, dut.state}, {29'd0, ST_HOLD});
        wait_tick();
        expect_key(KEY_DN);
        @(negedge vga_clk);

        // Inside the stop band (err = 305 - 304 = 1): back to HOLD.
        paddle_y = 10'd284;
        wait_tick();
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        check("stop_band_state", {29'd0, dut.state}, {29'd0, ST_HOLD});

        // Target clamps to 479, MOVE_DN; then the bottom limit guard.
        ball_y = 10'd500;
        wait_tick();
        expect_key(KEY_DN);
        @(negedge vga_clk);
        paddle_y = 10'd429;             // one above the limit: no change
        @(negedge vga_clk);
        paddle_y = 10'd430;             // 480 - 10 - 40
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        check("guard_dn_state", {29'd0, dut.state}, {29'd0, ST_MOVE_DN});
        paddle_y = 10'd400;
        expect_key(KEY_DN);
        @(negedge vga_clk);

        // Ball leaves: target 240, err = 240 - 320 = -80, reverse to MOVE_UP.
        ball_approach = 1'b0;
        paddle_y      = 10'd300;
        wait_tick();
        expect_key(KEY_UP);
        @(negedge vga_clk);
        paddle_y = 10'd11;              // one above the top limit: no change
        @(negedge vga_clk);
        paddle_y = 10'd10;
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        check("guard_up_state", {29'd0, dut.state}, {29'd0, ST_MOVE_UP});
        wait_tick();                    // err = 240 - 30 = 210: reverse
        expect_key(KEY_DN);
        @(negedge vga_clk);

        // guiwei during MOVE_DN with enable = 1.
        guiwei = 1'b1;
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        guiwei = 1'b0;
        check("guiwei_state", {29'd0, dut.state},  {29'd0, ST_HOLD});
        check("guiwei_div",   {10'd0, dut.div_cnt}, 32'd0);
        wait_tick();
        expect_key(KEY_DN);
        @(negedge vga_clk);

        // guiwei with enable = 0.
        guiwei = 1'b1;
        enable = 1'b0;
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        guiwei = 1'b0;
        check("guiwei_off_state", {29'd0, dut.state},  {29'd0, ST_IDLE});
        check("guiwei_off_div",   {10'd0, dut.div_cnt}, 32'd0);
        next_tick();
        next_tick();

        // Re-enable: HOLD on this tick, MOVE_DN on the next; then drop
        // enable on a tick cycle, which must win.
        enable = 1'b1;
        next_tick();
        expect_key(KEY_DN);
        next_tick();
        enable = 1'b0;
        expect_key(KEY_IDLE);
        @(negedge vga_clk);
        check("enable_drop_state", {29'd0, dut.state}, {29'd0, ST_IDLE});

        // sys_rst and guiwei together: reset wins (IDLE, LFSR reseeded).
        enable  = 1'b1;
        sys_rst = 1'b1;
        guiwei  = 1'b1;
        @(negedge vga_clk);
        sys_rst = 1'b0;
        guiwei  = 1'b0;
        enable  = 1'b0;
        check("rst_guiwei_state", {29'd0, dut.state},  {29'd0, ST_IDLE});
        check("rst_guiwei_lfsr",  {24'd0, dut.lfsr_q}, 32'hA5);

        repeat (4) @(negedge vga_clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
